sram128_req_ctrl: RTL and testbench

- Request front-end that directly drives the 128-bit single-port SRAM wrapper (524288x128, byte-write, active-low CEN/WEN).
- Converts a valid/ready request channel (read or byte-masked write) into SRAM strobes.
- Captures the one-cycle-latency read data and returns in-order responses through a small response FIFO with backpressure.
- Sits between the smart_run bus slave logic and the memory instance.

---
 rtl/sram128_req_ctrl_pkg.sv | 11 +
 rtl/sram128_req_ctrl_if.sv | 27 ++
 rtl/sram128_rsp_fifo.sv | 51 +++++
 rtl/sram128_req_ctrl.sv | 88 ++++++++
 tb/tb_sram128_req_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram128_req_ctrl_pkg.sv
// Shared constants and the response FIFO entry type for the 128-bit SRAM request controller.
package sram128_ctrl_pkg;
   localparam int DATA_W   = 128;
   localparam int STRB_W   = 16;
   localparam int BYTE_OFS = 4;

   typedef struct packed {
      logic              wr;
      logic [DATA_W-1:0] rdata;
   } rsp_entry_t;
endpackage

// File: rtl/sram128_req_ctrl_if.sv
// Request/response channel between the bus slave logic and the SRAM request controller.
interface sram128_req_ctrl_if #(
   parameter int ADDR_W = 19
);
   import sram128_ctrl_pkg::*;

   logic                       req_vld;
   logic                       req_rdy;
   logic                       req_wr;
   logic [ADDR_W+BYTE_OFS-1:0] req_addr;
   logic [DATA_W-1:0]          req_wdata;
   logic [STRB_W-1:0]          req_wstrb;
   logic                       rsp_vld;
   logic                       rsp_rdy;
   logic                       rsp_wr;
   logic [DATA_W-1:0]          rsp_rdata;

   modport master (
      output req_vld, req_wr, req_addr, req_wdata, req_wstrb, rsp_rdy,
      input  req_rdy, rsp_vld, rsp_wr, rsp_rdata
   );

   modport slave (
      input  req_vld, req_wr, req_addr, req_wdata, req_wstrb, rsp_rdy,
      output req_rdy, rsp_vld, rsp_wr, rsp_rdata
   );
endinterface

// File: rtl/sram128_rsp_fifo.sv
// Synchronous response FIFO; pointers wrap naturally because the depth is a power of two.
module sram128_rsp_fifo
   import sram128_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  rsp_entry_t       i_data,
   input  logic             i_pop,
   output rsp_entry_t       o_head,
   output logic [CNT_W-1:0] o_cnt
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
   end

   rsp_entry_t       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_cnt;
   logic             w_pop;

   assign w_pop  = i_pop && (r_cnt != '0);
   assign o_head = r_mem[r_rptr];
   assign o_cnt  = r_cnt;

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wptr] <= i_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({i_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end
endmodule

// File: rtl/sram128_req_ctrl.sv
// Request front-end for the 128-bit single-port SRAM: drives strobes on the accept cycle,
// captures read data one cycle later and returns in-order responses through a credit-checked FIFO.
module sram128_req_ctrl
   import sram128_ctrl_pkg::STRB_W, sram128_ctrl_pkg::BYTE_OFS, sram128_ctrl_pkg::rsp_entry_t;
#(
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 128,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               pll_core_cpuclk,
   input  logic               pad_cpu_rst_b,
   sram128_req_ctrl_if.slave  bus,
   output logic [ADDR_W-1:0]  sram_a,
   output logic               sram_cen,
   output logic [STRB_W-1:0]  sram_wen,
   output logic [DATA_W-1:0]  sram_d,
   input  logic [DATA_W-1:0]  sram_q
);
   localparam int               CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

   logic              r_run;
   logic              r_inflight;
   logic              r_infl_wr;
   logic [ADDR_W-1:0] r_a_hold;
   logic [DATA_W-1:0] r_d_hold;
   logic              w_fire;
   logic              w_pop;
   logic [CNT_W-1:0]  w_cnt;
   logic [CNT_W:0]    w_used;
   rsp_entry_t        w_push_ent;
   rsp_entry_t        w_head;
   logic              w_unused;

   assign w_unused = &{1'b0, bus.req_addr[BYTE_OFS-1:0]};

   // Credit check counts the in-flight access so the S1 push can never overflow the FIFO.
   assign w_used      = {1'b0, w_cnt} + (CNT_W + 1)'(r_inflight);
   assign bus.req_rdy = r_run && (w_used < DEPTH_C);
   assign w_fire      = bus.req_vld && bus.req_rdy;

   assign sram_cen = !w_fire;
   assign sram_wen = (w_fire && bus.req_wr) ? ~bus.req_wstrb : '1;
   assign sram_a   = w_fire ? bus.req_addr[ADDR_W+BYTE_OFS-1:BYTE_OFS] : r_a_hold;
   assign sram_d   = w_fire ? bus.req_wdata : r_d_hold;

   always_ff @(posedge pll_core_cpuclk) begin
      if (w_fire) begin
         r_a_hold <= bus.req_addr[ADDR_W+BYTE_OFS-1:BYTE_OFS];
         r_d_hold <= bus.req_wdata;
      end
   end

   always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
      if (!pad_cpu_rst_b) begin
         r_run      <= 1'b0;
         r_inflight <= 1'b0;
         r_infl_wr  <= 1'b0;
      end else begin
         r_run      <= 1'b1;
         r_inflight <= w_fire;
         if (w_fire) r_infl_wr <= bus.req_wr;
      end
   end

   // S1: the read data is on sram_q this cycle; write acks carry zero data.
   assign w_push_ent.wr    = r_infl_wr;
   assign w_push_ent.rdata = r_infl_wr ? '0 : sram_q;
   assign w_pop            = bus.rsp_vld && bus.rsp_rdy;

   sram128_rsp_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_rsp_fifo (
      .clk    (pll_core_cpuclk),
      .rst_n  (pad_cpu_rst_b),
      .i_push (r_inflight),
      .i_data (w_push_ent),
      .i_pop  (w_pop),
      .o_head (w_head),
      .o_cnt  (w_cnt)
   );

   assign bus.rsp_vld   = (w_cnt != '0);
   assign bus.rsp_wr    = bus.rsp_vld && w_head.wr;
   assign bus.rsp_rdata = bus.rsp_vld ? w_head.rdata : '0;

   a_req_hold: assert property (@(posedge pll_core_cpuclk) disable iff (!pad_cpu_rst_b)
      (bus.req_vld && !bus.req_rdy) |=>
      (!bus.req_vld || $stable({bus.req_wr, bus.req_addr, bus.req_wdata, bus.req_wstrb})));
endmodule

// File: tb/tb_sram128_req_ctrl.sv
// Scoreboard bench: a byte-level SRAM model answers the strobes, a reference memory predicts responses.
module tb_sram128_req_ctrl;
   localparam int ADDR_W = 19;
   localparam int AW     = ADDR_W + 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sram128_req_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
   logic [ADDR_W-1:0] sram_a;
   logic              sram_cen;
   logic [15:0]       sram_wen;
   logic [127:0]      sram_d;
   logic [127:0]      sram_q;

   sram128_req_ctrl #(.ADDR_W(ADDR_W), .DATA_W(128), .FIFO_DEPTH(4)) dut (
      .pll_core_cpuclk (clk),
      .pad_cpu_rst_b   (rst_n),
      .bus             (bus),
      .sram_a          (sram_a),
      .sram_cen        (sram_cen),
      .sram_wen        (sram_wen),
      .sram_d          (sram_d),
      .sram_q          (sram_q)
   );

   typedef struct {
      bit           wr;
      logic [127:0] data;
      int           acc;
      bit           exact;
   } exp_t;

   exp_t              exp_q[$];
   logic [127:0]      ref_mem [logic [ADDR_W-1:0]];
   logic [127:0]      smem    [logic [ADDR_W-1:0]];
   int                checks = 0;
   int                errors = 0;
   int                cyc = 0;
   int                stalls = 0;
   bit                exact_mode = 1'b1;
   bit                have_last = 1'b0;
   logic [ADDR_W-1:0] last_a;
   logic [127:0]      last_d;

   function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endfunction

   function automatic void accept_model(input bit wr, input logic [AW-1:0] addr,
                                        input logic [127:0] d, input logic [15:0] s);
      logic [ADDR_W-1:0] wa;
      logic [127:0]      cur;
      exp_t              e;
      wa  = addr[AW-1:4];
      cur = ref_mem.exists(wa) ? ref_mem[wa] : '0;
      if (wr) begin
         for (int b = 0; b < 16; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
         ref_mem[wa] = cur;
         e = '{wr: 1'b1, data: '0, acc: cyc, exact: exact_mode};
      end else begin
         e = '{wr: 1'b0, data: cur, acc: cyc, exact: exact_mode};
      end
      exp_q.push_back(e);
      last_a    = wa;
      last_d    = d;
      have_last = 1'b1;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // SRAM model: strobes sampled mid-cycle, applied at the edge; q is garbage except after a read.
   logic              m_cen;
   logic [15:0]       m_wen;
   logic [ADDR_W-1:0] m_a;
   logic [127:0]      m_d;
   logic [127:0]      m_w;
   initial begin
      sram_q = '0;
      forever begin
         @(negedge clk);
         m_cen = sram_cen; m_wen = sram_wen; m_a = sram_a; m_d = sram_d;
         @(posedge clk);
         if (!m_cen && m_wen != 16'hFFFF) begin
            m_w = smem.exists(m_a) ? smem[m_a] : '0;
            for (int b = 0; b < 16; b++) if (!m_wen[b]) m_w[8*b +: 8] = m_d[8*b +: 8];
            smem[m_a] = m_w;
            sram_q <= {$urandom, $urandom, $urandom, $urandom};
         end else if (!m_cen) begin
            sram_q <= smem.exists(m_a) ? smem[m_a] : '0;
         end else begin
            sram_q <= {$urandom, $urandom, $urandom, $urandom};
         end
      end
   end

   exp_t         mon_e;
   bit           prev_hold = 1'b0;
   logic         prev_wr;
   logic [127:0] prev_rd;
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("rsp_stable_vld", bus.rsp_vld, 1);
            chk("rsp_stable_wr", bus.rsp_wr, prev_wr);
            chk("rsp_stable_rdata", bus.rsp_rdata, prev_rd);
         end
         if (bus.rsp_vld && bus.rsp_rdy) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rsp_unexpected actual=response required=none");
            end else begin
               mon_e = exp_q.pop_front();
               chk("rsp_wr", bus.rsp_wr, mon_e.wr);
               chk("rsp_rdata", bus.rsp_rdata, mon_e.data);
               if (mon_e.exact) chk("rsp_latency", cyc - mon_e.acc, 2);
               else begin
                  checks++;
                  if (cyc - mon_e.acc < 2) begin
                     errors++;
                     $display("FAIL rsp_min_latency actual=%0d required>=2", cyc - mon_e.acc);
                  end
               end
            end
         end
         prev_hold = bus.rsp_vld && !bus.rsp_rdy;
         prev_wr   = bus.rsp_wr;
         prev_rd   = bus.rsp_rdata;
         if (!bus.req_vld || !bus.req_rdy) begin
            chk("idle_cen", sram_cen, 1);
            chk("idle_wen", sram_wen, 16'hFFFF);
            if (have_last) begin
               chk("idle_a_hold", sram_a, last_a);
               chk("idle_d_hold", sram_d, last_d);
            end
         end
      end
   end

   task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [127:0] d, input logic [15:0] s);
      int          w = 0;
      bit          ok = 1'b0;
      logic [15:0] exp_wen;
      bus.req_vld = 1'b1; bus.req_wr = wr; bus.req_addr = addr;
      bus.req_wdata = d; bus.req_wstrb = s;
      while (!ok && w < 300) begin
         @(negedge clk);
         if (bus.req_rdy) ok = 1'b1;
         else w++;
      end
      stalls += w;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL req_accept_timeout actual=no_accept required=accept");
      end else begin
         exp_wen = wr ? ~s : 16'hFFFF;
         chk("sram_cen", sram_cen, 0);
         chk("sram_a", sram_a, addr[AW-1:4]);
         chk("sram_d", sram_d, d);
         chk("sram_wen", sram_wen, exp_wen);
         accept_model(wr, addr, d, s);
      end
      @(posedge clk); #1;
      bus.req_vld = 1'b0;
   endtask

   task automatic wait_drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 500) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cen"}, sram_cen, 1);
      chk({tag, "_wen"}, sram_wen, 16'hFFFF);
      chk({tag, "_rsp_vld"}, bus.rsp_vld, 0);
      chk({tag, "_rsp_wr"}, bus.rsp_wr, 0);
      chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
      chk({tag, "_req_rdy"}, bus.req_rdy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   logic [127:0] rd;
   logic [15:0]  rs;
   int           acc;
   int           idx;
   bit           fired;
   bit           rand_on;

   initial begin
      bus.req_vld = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0;
      bus.req_wdata = '0; bus.req_wstrb = '0; bus.rsp_rdy = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("por");
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("rdy_after_por", bus.req_rdy, 1);
      @(posedge clk); #1;

      // single write then read
      issue(1'b1, 23'h10, 128'h00112233445566778899AABBCCDDEEFF, 16'hFFFF);
      issue(1'b0, 23'h10, '0, '0);
      wait_drain();

      // byte mask
      issue(1'b1, 23'h40, {16{8'hAA}}, 16'hFFFF);
      issue(1'b1, 23'h40, {16{8'h55}}, 16'h00F0);
      issue(1'b0, 23'h40, '0, '0);
      wait_drain();

      // streaming: preload then 64 back-to-back reads
      for (int i = 0; i < 64; i++) issue(1'b1, AW'((32'h100 + i) << 4), {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
      stalls = 0;
      for (int i = 0; i < 64; i++) issue(1'b0, AW'((32'h100 + i) << 4), '0, '0);
      chk("stream_stalls", stalls, 0);
      wait_drain();

      // backpressure
      exact_mode = 1'b0;
      bus.rsp_rdy = 1'b0;
      acc = 0; idx = 0;
      bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_wdata = '0; bus.req_wstrb = '0;
      bus.req_addr = AW'((32'h100 + idx) << 4);
      for (int c = 0; c < 18; c++) begin
         if (c == 10) chk("bp_accepts", acc, 4);
         if (c == 10) begin
            @(negedge clk);
            chk("bp_rdy_low", bus.req_rdy, 0);
            @(posedge clk); #1;
            bus.rsp_rdy = 1'b1;
            acc = 0;
         end
         @(negedge clk);
         fired = bus.req_rdy;
         if (fired) begin
            accept_model(1'b0, bus.req_addr, bus.req_wdata, bus.req_wstrb);
            acc++;
         end
         @(posedge clk); #1;
         bus.rsp_rdy = 1'b0;
         if (fired) begin
            idx++;
            bus.req_addr = AW'((32'h100 + idx) << 4);
         end
      end
      chk("bp_one_more_accept", acc, 1);
      bus.req_vld = 1'b0;
      bus.rsp_rdy = 1'b1;
      wait_drain();

      // reset mid-operation: pending responses dropped, a pending write never reaches the SRAM
      bus.rsp_rdy = 1'b0;
      issue(1'b0, 23'h10, '0, '0);
      issue(1'b0, 23'h40, '0, '0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      bus.req_vld = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 23'h10;
      bus.req_wdata = {4{32'hDEADBEEF}}; bus.req_wstrb = 16'hFFFF;
      #1;
      check_reset_outputs("mid_rst");
      exp_q.delete();
      @(posedge clk); #1 bus.req_vld = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("rdy_after_mid_rst", bus.req_rdy, 1);
      @(posedge clk); #1;
      bus.rsp_rdy = 1'b1;
      exact_mode = 1'b1;
      issue(1'b0, 23'h10, '0, '0);
      wait_drain();

      // top word address and zero-strobe write
      rd = {$urandom, $urandom, $urandom, $urandom};
      issue(1'b1, 23'h7FFFF0, rd, 16'hFFFF);
      issue(1'b0, 23'h7FFFF0, '0, '0);
      issue(1'b1, 23'h7FFFF0, ~rd, 16'h0000);
      issue(1'b0, 23'h7FFFF0, '0, '0);
      wait_drain();

      // random mixed traffic with random response backpressure
      exact_mode = 1'b0;
      rand_on = 1'b1;
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               rd = {$urandom, $urandom, $urandom, $urandom};
               rs = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
               issue(1'($urandom_range(0, 1)), AW'((32'h200 + $urandom_range(0, 15)) << 4), rd, rs);
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk); #1;
               end
            end
            rand_on = 1'b0;
         end
         begin
            while (rand_on) begin
               @(posedge clk); #1;
               if (rand_on) bus.rsp_rdy = 1'($urandom_range(0, 1));
            end
         end
      join
      bus.rsp_rdy = 1'b1;
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
